// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency) between
// instruction fetch (read), load/store (read/write) and the UART program
// loader (write). The grant is decided combinationally in cycle N and drives
// mem_* directly. The owner is registered at the end of N, and the matching
// valid/ack pulse is decoded from it in N+1. Grants may issue every cycle.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   if_req/if_addr           fetch read request  -> if_rdata/if_valid
//   d_req/d_we/d_addr/d_wdata data access request -> d_rdata/d_valid
//   ld_mode                  1 = loader owns the RAM, fetch/data ignored
//   ld_req/ld_addr/ld_wdata  loader write request -> ld_ack
//   mem_en/we/addr/wdata     RAM command, mem_rdata RAM read data
//   pc_stall                 freeze PC while fetch is not being served
//
// Optional feature, macro ARB_PERF_CNT_EN: adds the stall_cycles and
// conflict_cycles performance counters as outputs.
module imem_port_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   input  logic              ld_mode,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              pc_stall
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       conflict_cycles
`endif
);

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D, OWN_LD} owner_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   owner_e            owner_q, owner_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   // Grant decision and RAM command. With no grant, address and write data
   // keep their last values so the RAM pins do not toggle needlessly.
   always_comb begin
      owner_d      = OWN_NONE;
      starve_cnt_d = starve_cnt_q;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = addr_q;
      mem_wdata    = wdata_q;
      if (reset) begin
         // No new access starts while reset is held.
         starve_cnt_d = 4'd0;
      end else if (ld_mode) begin
         starve_cnt_d = 4'd0;
         if (ld_req) begin
            owner_d   = OWN_LD;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
         end
      end else begin
         // Data has priority unless fetch has waited STARVE_LIMIT data grants.
         if (if_req && (starve_cnt_q == LIMIT || !d_req)) begin
            owner_d  = OWN_IF;
            mem_en   = 1'b1;
            mem_addr = if_addr;
         end else if (d_req) begin
            owner_d   = OWN_D;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
         end
         if (!if_req || owner_d == OWN_IF)
            starve_cnt_d = 4'd0;
         else if (owner_d == OWN_D && starve_cnt_q != 4'hF)
            starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   assign pc_stall = ld_mode | (if_req & (owner_d != OWN_IF));

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q      <= OWN_NONE;
         starve_cnt_q <= 4'd0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= mem_addr;
         wdata_q      <= mem_wdata;
      end
   end

   // A grant still outstanding when reset arrives is dropped silently.
   assign if_valid = (owner_q == OWN_IF) & ~reset;
   assign d_valid  = (owner_q == OWN_D)  & ~reset;
   assign ld_ack   = (owner_q == OWN_LD) & ~reset;
   assign if_rdata = mem_rdata;
   assign d_rdata  = mem_rdata;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] stall_cycles_q, conflict_cycles_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q    <= 32'd0;
         conflict_cycles_q <= 32'd0;
      end else if (!ld_mode) begin
         if (pc_stall)        stall_cycles_q    <= stall_cycles_q + 32'd1;
         if (if_req && d_req) conflict_cycles_q <= conflict_cycles_q + 32'd1;
      end
   end

   assign stall_cycles    = stall_cycles_q;
   assign conflict_cycles = conflict_cycles_q;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: directed table, starvation / reset
// sequences, then randomized traffic checked against a transaction model.
module tb_imem_port_arbiter;
   localparam int AW  = 14;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          if_req, if_valid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_valid;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          ld_mode, ld_req, ld_ack;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          mem_en, mem_we, pc_stall;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]   stall_cycles, conflict_cycles;
`endif

   imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .ld_mode(ld_mode), .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_ack(ld_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .pc_stall(pc_stall)
`ifdef ARB_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .conflict_cycles(conflict_cycles)
`endif
   );

   // Environment RAM (read-first, 1-cycle latency) and the model's own copy.
   logic [DW-1:0] ram  [0:(1<<AW)-1];
   logic [DW-1:0] mram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic init_rams;
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i]  = 32'hC0DE_0000 + i;
         mram[i] = 32'hC0DE_0000 + i;
      end
      ram[14'h010] = 32'h2008_0005; mram[14'h010] = 32'h2008_0005;
      ram[14'h100] = 32'h1234_5678; mram[14'h100] = 32'h1234_5678;
   endtask

   task automatic idle;
      if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      ld_mode = 0; ld_req = 0; ld_addr = '0; ld_wdata = '0;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic mid;
      #4;
   endtask

   task automatic do_reset;
      reset = 1; idle;
      tick; tick;
      reset = 0;
   endtask

   task automatic chk_pulses(input string nm, input logic iv, input logic dv, input logic ak);
      chk({nm, ".if_valid"}, 32'(if_valid), 32'(iv));
      chk({nm, ".d_valid"},  32'(d_valid),  32'(dv));
      chk({nm, ".ld_ack"},   32'(ld_ack),   32'(ak));
   endtask

   typedef struct packed {
      logic          ldm, ifr;
      logic [AW-1:0] ifa;
      logic          dr, dwe;
      logic [AW-1:0] da;
      logic [DW-1:0] dwd;
      logic          lr;
      logic [AW-1:0] la;
      logic [DW-1:0] lwd;
      logic          en, we;
      logic [AW-1:0] addr;
      logic          stall, ifv, dv, ack;
      logic [DW-1:0] rd;
   } vec_t;

   vec_t vecs [0:8];

   initial begin
      int s, pw, w;
      logic [AW-1:0] laddr;
      logic [DW-1:0] exp_rd;
      logic pi, pd, pl, mode, e_we;
      int m_stall, m_conf;

      //             ldm ifr ifa     dr dwe da      dwd lr la     lwd            en we addr    st iv dv ak rd
      vecs[0] = '{1'b0,1'b1,14'h010,1'b0,1'b0,14'h000,32'h0,1'b0,14'h0,32'h0,         1'b1,1'b0,14'h010,1'b0,1'b0,1'b0,1'b0,32'h0};
      vecs[1] = '{1'b0,1'b0,14'h000,1'b0,1'b0,14'h000,32'h0,1'b0,14'h0,32'h0,         1'b0,1'b0,14'h010,1'b0,1'b1,1'b0,1'b0,32'h2008_0005};
      vecs[2] = '{1'b0,1'b1,14'h020,1'b1,1'b0,14'h100,32'h0,1'b0,14'h0,32'h0,         1'b1,1'b0,14'h100,1'b1,1'b0,1'b0,1'b0,32'h0};
      vecs[3] = '{1'b0,1'b1,14'h020,1'b0,1'b0,14'h000,32'h0,1'b0,14'h0,32'h0,         1'b1,1'b0,14'h020,1'b0,1'b0,1'b1,1'b0,32'h1234_5678};
      vecs[4] = '{1'b0,1'b0,14'h000,1'b0,1'b0,14'h000,32'h0,1'b0,14'h0,32'h0,         1'b0,1'b0,14'h020,1'b0,1'b1,1'b0,1'b0,32'hC0DE_0020};
      vecs[5] = '{1'b1,1'b1,14'h003,1'b0,1'b0,14'h000,32'h0,1'b1,14'h3,32'hDEAD_BEEF, 1'b1,1'b1,14'h003,1'b1,1'b0,1'b0,1'b0,32'h0};
      vecs[6] = '{1'b1,1'b1,14'h003,1'b0,1'b0,14'h000,32'h0,1'b0,14'h0,32'h0,         1'b0,1'b0,14'h003,1'b1,1'b0,1'b0,1'b1,32'h0};
      vecs[7] = '{1'b0,1'b1,14'h003,1'b0,1'b0,14'h000,32'h0,1'b0,14'h0,32'h0,         1'b1,1'b0,14'h003,1'b0,1'b0,1'b0,1'b0,32'h0};
      vecs[8] = '{1'b0,1'b0,14'h000,1'b0,1'b0,14'h000,32'h0,1'b0,14'h0,32'h0,         1'b0,1'b0,14'h003,1'b0,1'b1,1'b0,1'b0,32'hDEAD_BEEF};

      init_rams;
      do_reset;

      // First cycle after reset: nothing pending.
      mid;
      chk_pulses("post_reset", 0, 0, 0);
      chk("post_reset.mem_en", 32'(mem_en), 0);
      tick;

      // Directed table: fetch, D-over-IF conflict, loader write, fetch-back.
      for (int i = 0; i <= 8; i++) begin
         ld_mode = vecs[i].ldm; if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
         d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da; d_wdata = vecs[i].dwd;
         ld_req = vecs[i].lr; ld_addr = vecs[i].la; ld_wdata = vecs[i].lwd;
         mid;
         chk($sformatf("vec%0d.mem_en", i),   32'(mem_en),   32'(vecs[i].en));
         chk($sformatf("vec%0d.mem_we", i),   32'(mem_we),   32'(vecs[i].we));
         chk($sformatf("vec%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
         chk($sformatf("vec%0d.pc_stall", i), 32'(pc_stall), 32'(vecs[i].stall));
         chk_pulses($sformatf("vec%0d", i), vecs[i].ifv, vecs[i].dv, vecs[i].ack);
         if (vecs[i].we) chk($sformatf("vec%0d.mem_wdata", i), mem_wdata, vecs[i].lwd);
         if (vecs[i].ifv) chk($sformatf("vec%0d.if_rdata", i), if_rdata, vecs[i].rd);
         if (vecs[i].dv)  chk($sformatf("vec%0d.d_rdata", i),  d_rdata,  vecs[i].rd);
         tick;
      end
`ifdef ARB_PERF_CNT_EN
      chk("perf.stall_cycles",    stall_cycles,    1);
      chk("perf.conflict_cycles", conflict_cycles, 1);
`endif

      // Starvation: 10 store requests with fetch waiting; IF forced at 4 and 9.
      do_reset;
      for (int c = 0; c < 10; c++) begin
         logic ifw, prev_ifw;
         ifw = (c == 4 || c == 9);
         prev_ifw = (c == 5);
         if_req = 1; if_addr = 14'h050;
         d_req = 1; d_we = 1; d_addr = 14'h200 + 14'(c); d_wdata = 32'(c);
         mid;
         chk($sformatf("starve%0d.mem_we", c),   32'(mem_we),   32'(!ifw));
         chk($sformatf("starve%0d.pc_stall", c), 32'(pc_stall), 32'(!ifw));
         chk($sformatf("starve%0d.mem_addr", c), 32'(mem_addr), ifw ? 32'h50 : 32'h200 + c);
         if (c > 0) chk_pulses($sformatf("starve%0d", c), prev_ifw, !prev_ifw, 0);
         tick;
      end
      idle; mid;
      chk_pulses("starve_end", 1, 0, 0);
      tick;

      // Reset mid-operation: build starvation count to the limit, then reset
      // in the cycle after a D load grant.
      do_reset;
      for (int c = 0; c < 4; c++) begin
         if_req = 1; if_addr = 14'h060; d_req = 1; d_we = 0; d_addr = 14'h100;
         mid;
         chk($sformatf("rst_pre%0d.pc_stall", c), 32'(pc_stall), 1);
         tick;
      end
      reset = 1; idle; mid;
      chk("rst_mid.d_valid", 32'(d_valid), 0);
      tick;
      reset = 0; mid;
      chk_pulses("rst_after", 0, 0, 0);
      tick;
      for (int c = 0; c < 5; c++) begin
         if_req = 1; if_addr = 14'h060; d_req = 1; d_we = 0; d_addr = 14'h100;
         mid;
         chk($sformatf("rst_post%0d.mem_addr", c), 32'(mem_addr), (c == 4) ? 32'h60 : 32'h100);
         tick;
      end

      // Randomized traffic against the transaction model.
      do_reset;
      init_rams;
      s = 0; pw = 0; laddr = '0; exp_rd = '0;
      pi = 0; pd = 0; pl = 0; mode = 0; m_stall = 0; m_conf = 0;
      for (int n = 0; n < 2000; n++) begin
         if (pw == 1) pi = 0;
         if (pw == 2) pd = 0;
         if (pw == 3) pl = 0;
         if (!pi && $urandom_range(2) == 0) begin pi = 1; if_addr = AW'($urandom_range(31)); end
         if (!pd && $urandom_range(2) == 0) begin
            pd = 1; d_addr = AW'($urandom_range(31)); d_we = 1'($urandom_range(1)); d_wdata = $urandom;
         end
         if (!pl && $urandom_range(1) == 0) begin
            pl = 1; ld_addr = AW'($urandom_range(31)); ld_wdata = $urandom;
         end
         if ($urandom_range(39) == 0) mode = ~mode;
         if_req = pi; d_req = pd; ld_req = pl; ld_mode = mode;

         // Who the rules say wins this cycle: 0 none, 1 fetch, 2 data, 3 loader.
         if (mode)                             w = pl ? 3 : 0;
         else if (pi && (s == LIM || !pd))     w = 1;
         else if (pd)                          w = 2;
         else                                  w = 0;
         e_we = (w == 3) || (w == 2 && d_we);
         if (w == 1) laddr = if_addr;
         if (w == 2) laddr = d_addr;
         if (w == 3) laddr = ld_addr;

         mid;
         chk("rnd.mem_en",   32'(mem_en),   32'(w != 0));
         chk("rnd.mem_we",   32'(mem_we),   32'(e_we));
         chk("rnd.mem_addr", 32'(mem_addr), 32'(laddr));
         if (e_we) chk("rnd.mem_wdata", mem_wdata, (w == 3) ? ld_wdata : d_wdata);
         chk("rnd.pc_stall", 32'(pc_stall), 32'(mode || (pi && w != 1)));
         chk_pulses("rnd", pw == 1, pw == 2, pw == 3);
         if (pw == 1) chk("rnd.if_rdata", if_rdata, exp_rd);
         if (pw == 2) chk("rnd.d_rdata",  d_rdata,  exp_rd);

         if (w != 0) begin
            exp_rd = mram[laddr];
            if (e_we) mram[laddr] = (w == 3) ? ld_wdata : d_wdata;
         end
         if (mode || !pi || w == 1) s = 0;
         else if (w == 2 && s < 15) s = s + 1;
         if (!mode && pc_stall) m_stall++;
         if (!mode && pi && pd) m_conf++;
         pw = w;
         tick;
      end
`ifdef ARB_PERF_CNT_EN
      chk("rnd.stall_cycles",    stall_cycles,    32'(m_stall));
      chk("rnd.conflict_cycles", conflict_cycles, 32'(m_conf));
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
